pipe_delay_ctrl: RTL

- Parametrised successor to the fixed-length valid/data delay line used between NTT pipeline stages (butterfly, modular multiplier, twiddle fetch).
- Adds a pipeline-wide advance enable (stall), a synchronous flush, and a runtime-selectable latency.
- Adds an in-flight counter and busy flag, so the NTT controller can align data and valid of variable-latency arithmetic units and detect when the pipe has drained.

---
 rtl/pipe_delay_pkg.sv | 16 +
 rtl/pipe_stage.sv | 29 ++
 rtl/pipe_delay_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_delay_pkg.sv
// Shared types and helpers for the NTT pipeline delay line.
// stage_t documents one entry at the default 16-bit width.
package pipe_delay_pkg;

   localparam int STAGE_WIDTH = 16;

   typedef struct packed {
      logic                   v;
      logic [STAGE_WIDTH-1:0] d;
   } stage_t;

   function automatic logic lat_legal(input int unsigned lat, input int unsigned max);
      return (lat >= 1) && (lat <= max);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, data} register of the delay line.
// clr wipes both fields; v_clr drops only the valid bit.
module pipe_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             v_clr,
   input  logic             en,
   input  logic             v_in,
   input  logic [WIDTH-1:0] d_in,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         v <= 1'b0;
         d <= '0;
      end else if (v_clr) begin
         v <= 1'b0;
      end else if (en) begin
         v <= v_in;
         d <= d_in;
      end
   end

endmodule

// File: rtl/pipe_delay_ctrl.sv
// Variable-latency valid/data delay line with stall, flush, in-flight count
// and a guarded runtime latency change for NTT pipeline stage alignment.
module pipe_delay_ctrl
   import pipe_delay_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int MAX_STAGES  = 8,
   parameter int DEFAULT_LAT = MAX_STAGES,
   parameter int CW          = $clog2(MAX_STAGES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             lat_we_i,
   input  logic [CW-1:0]    lat_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    lat_o,
   output logic [CW-1:0]    count_o,
   output logic             busy_o,
   output logic             lat_err_o
);

   logic             v_q [MAX_STAGES];
   logic [WIDTH-1:0] d_q [MAX_STAGES];

   logic [CW-1:0]    lat_r;
   logic [CW-1:0]    count_r;
   logic             lat_err_r;
   logic [CW-1:0]    tap;
   logic             tap_v;
   logic [WIDTH-1:0] tap_d;
   logic             lat_accept;
   logic             adv;
   logic [CW-1:0]    pop_cnt;

   // A latency change is only safe on an empty pipe with nothing entering,
   // otherwise in-flight entries would be emitted at the wrong time.
   assign lat_accept = lat_we_i && !flush_i && (count_r == '0) && !(en_i && valid_i)
                       && lat_legal(32'(lat_i), MAX_STAGES);
   assign adv        = en_i && !lat_accept;

   generate
      for (genvar k = 0; k < MAX_STAGES; k++) begin : g_stage
         if (k == 0) begin : g_head
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .clk   (clk),
               .reset (reset),
               .clr   (flush_i),
               .v_clr (lat_accept),
               .en    (adv),
               .v_in  (valid_i),
               .d_in  (data_i),
               .v     (v_q[k]),
               .d     (d_q[k])
            );
         end else begin : g_body
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .clk   (clk),
               .reset (reset),
               .clr   (flush_i),
               .v_clr (lat_accept),
               .en    (adv),
               .v_in  (v_q[k-1]),
               .d_in  (d_q[k-1]),
               .v     (v_q[k]),
               .d     (d_q[k])
            );
         end
      end
   endgenerate

   assign tap = lat_r - CW'(1);

   always_comb begin
      tap_v = 1'b0;
      tap_d = '0;
      for (int k = 0; k < MAX_STAGES; k++) begin
         if (tap == CW'(k)) begin
            tap_v = v_q[k];
            tap_d = d_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_r     <= CW'(DEFAULT_LAT);
         count_r   <= '0;
         lat_err_r <= 1'b0;
      end else begin
         lat_err_r <= lat_we_i && !flush_i && !lat_accept;
         if (flush_i) begin
            count_r <= '0;
         end else if (lat_accept) begin
            lat_r   <= lat_i;
            count_r <= '0;
         end else if (en_i) begin
            count_r <= count_r + CW'(valid_i) - CW'(tap_v);
         end
      end
   end

   assign valid_o   = tap_v;
   assign data_o    = tap_d;
   assign lat_o     = lat_r;
   assign count_o   = count_r;
   assign busy_o    = (count_r != '0);
   assign lat_err_o = lat_err_r;

   // Reference popcount over the observable stages, used only by the checks.
   always_comb begin
      pop_cnt = '0;
      for (int k = 0; k < MAX_STAGES; k++) begin
         if (CW'(k) < lat_r) pop_cnt = pop_cnt + CW'(v_q[k]);
      end
   end

   a_count_matches: assert property (@(posedge clk) disable iff (reset) count_r == pop_cnt);
   a_count_bound:   assert property (@(posedge clk) disable iff (reset) count_r <= lat_r);

endmodule
